mem_dump_streamer: RTL and testbench

//  - Write-side counterpart of the memory-image load path: walks a synchronous RAM read port

---
 rtl/mem_dump_pkg.sv | 16 +
 rtl/mem_dump_fifo2.sv | 42 ++++
 rtl/mem_dump_streamer.sv | 118 +++++++++++
 tb/tb_mem_dump_streamer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types for the memory dump streamer: FSM states and the beat carried
// from the RAM read port to the output stream.
package mem_dump_pkg;

  localparam int DUMP_ADDR_W = 8;
  localparam int DUMP_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dump_state_e;

  typedef struct packed {
    logic [DUMP_ADDR_W-1:0] addr;
    logic [DUMP_DATA_W-1:0] data;
    logic                   last;
  } dump_beat_t;

endpackage

// File: rtl/mem_dump_fifo2.sv
// Two-entry show-ahead FIFO; the head entry is always visible on dout.
// The caller guarantees no push when full and no pop when empty.
module mem_dump_fifo2
  import mem_dump_pkg::*;
#(
  parameter type beat_t = dump_beat_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  beat_t      din,
  output beat_t      dout,
  output logic       valid,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks a 1-cycle-latency RAM read port over [base, base+len) and streams each
// word with its address on a valid/ready interface, tolerating any backpressure.
module mem_dump_streamer
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  dump_state_e       state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_left;
  logic [ADDR_W-1:0] fl_addr;
  logic              fl_vld;
  logic              fl_last;
  logic              rd_go;
  logic              rd_last;
  logic              pop;
  logic              fifo_vld;
  logic [1:0]        fifo_cnt;
  logic [2:0]        credits_used;
  beat_t             head;
  beat_t             push_beat;

  assign pop     = fifo_vld & out_ready_i;
  assign rd_last = (rd_left == (ADDR_W+1)'(1));
  // A word leaving the FIFO this cycle frees its slot in time for a new read.
  assign credits_used = {1'b0, fifo_cnt} + {2'b0, fl_vld} - {2'b0, pop};

  always_comb begin
    state_nxt = state;
    rd_go     = 1'b0;
    case (state)
      IDLE:  if (start_i) state_nxt = (len_i == '0) ? DONE : RUN;
      RUN: begin
        rd_go = (credits_used < 3'd2);
        if (rd_go && rd_last) state_nxt = DRAIN;
      end
      DRAIN: if (pop && head.last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Read walker plus the one-deep record of the read whose data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_left <= '0;
      fl_vld  <= 1'b0;
      fl_addr <= '0;
      fl_last <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        rd_addr <= base_i;
        rd_left <= len_i;
      end else if (rd_go) begin
        rd_addr <= rd_addr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
      fl_vld <= rd_go;
      if (rd_go) begin
        fl_addr <= rd_addr;
        fl_last <= rd_last;
      end
    end
  end

  assign push_beat = {fl_addr, mem_rdata_i, fl_last};

  mem_dump_fifo2 #(.beat_t(beat_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fl_vld),
    .pop   (pop),
    .din   (push_beat),
    .dout  (head),
    .valid (fifo_vld),
    .count (fifo_cnt)
  );

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign mem_rd_en_o = rd_go;
  assign mem_addr_o  = rd_addr;
  assign out_valid_o = fifo_vld;
  assign out_data_o  = head.data;
  assign out_addr_o  = head.addr;
  assign out_last_o  = fifo_vld & head.last;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Bench for mem_dump_streamer: RAM image model, expected-word scoreboard checked
// every cycle, and directed scenarios with hand-computed cycle/value expectations.
module tb_mem_dump_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  base_i = '0;
  logic [8:0]  len_i = '0;
  logic        busy_o, done_o, mem_rd_en_o, out_valid_o, out_last_o;
  logic [7:0]  mem_addr_o, out_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] out_data_o;
  logic        out_ready_i = 1'b1;
  bit          rnd_mode = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int issued = 0, popped = 0;
  int rd_cnt = 0, hs_cnt = 0, vld_cnt = 0, done_cnt = 0;
  int rd_rise_cyc = -1, rd_last_cyc = -1, vld_rise_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  logic [31:0] last_hs_data = '0;
  logic [40:0] exp_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  addr_log[$];
  logic        hs, prev_stall = 1'b0, prev_vld = 1'b0, prev_rd = 1'b0;
  logic [40:0] prev_word = '0, e;
  logic [7:0]  ra;

  mem_dump_streamer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_addr_o(out_addr_o), .out_last_o(out_last_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] img(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  always @(posedge clk) if (mem_rd_en_o) mem_rdata_i <= img(mem_addr_o);

  always @(posedge clk) begin
    #1;
    out_ready_i = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: words leave in order with the right address/data/last, reads walk
  // the expected addresses, at most 2 words outstanding, stalled outputs hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); rd_q.delete();
      issued = 0; popped = 0;
      prev_stall = 1'b0; prev_vld = 1'b0; prev_rd = 1'b0;
    end else begin
      hs = out_valid_o && out_ready_i;
      if (prev_stall)
        chk("stall_hold", {out_valid_o, out_last_o, out_addr_o, out_data_o}, {1'b1, prev_word});
      if (mem_rd_en_o) begin
        chk("credit", (issued - popped - (hs ? 1 : 0)) < 2, 1);
        chk("rd_pending", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          ra = rd_q.pop_front();
          chk("rd_addr", mem_addr_o, ra);
        end
        issued++; rd_cnt++;
        if (!prev_rd) rd_rise_cyc = cyc;
        rd_last_cyc = cyc;
      end
      if (out_valid_o) begin
        vld_cnt++;
        if (!prev_vld) vld_rise_cyc = cyc;
      end
      if (hs) begin
        chk("hs_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat", {out_last_o, out_addr_o, out_data_o}, e);
        end
        popped++; hs_cnt++;
        addr_log.push_back(out_addr_o);
        if (out_last_o) begin
          last_hs_cyc = cyc;
          last_hs_data = out_data_o;
        end
      end
      if (done_o) begin
        done_cnt++; done_cyc = cyc;
        chk("done_vs_last", hs && out_last_o, 0);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_word  = {out_last_o, out_addr_o, out_data_o};
      prev_vld   = out_valid_o;
      prev_rd    = mem_rd_en_o;
    end
  end

  // s = cycle number in which the DUT first acts on the accepted start
  task automatic start_dump(input logic [7:0] b, input logic [8:0] l, input bit model, output int s);
    logic [7:0] a;
    @(posedge clk); #1;
    start_i = 1'b1; base_i = b; len_i = l;
    if (model)
      for (int i = 0; i < int'(l); i++) begin
        a = b + 8'(i);
        rd_q.push_back(a);
        exp_q.push_back({(i == int'(l) - 1), a, img(a)});
      end
    @(posedge clk); #1;
    s = cyc;
    start_i = 1'b0; base_i = '0; len_i = '0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", done_cnt != d0, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_rd_en"}, mem_rd_en_o, 0);
    chk({nm, "_mem_addr"}, mem_addr_o, 0);
    chk({nm, "_valid"}, out_valid_o, 0);
    chk({nm, "_data"}, out_data_o, 0);
    chk({nm, "_addr"}, out_addr_o, 0);
    chk({nm, "_last"}, out_last_o, 0);
  endtask

  initial begin
    int s, r0, h0, d0, v0, la, n;
    logic [7:0] exp_a [4];

    #12 chk_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // back-to-back dump of 0x10..0x13
    r0 = rd_cnt; h0 = hs_cnt; d0 = done_cnt;
    start_dump(8'h10, 9'd4, 1'b1, s);
    @(negedge clk) chk("busy_run", busy_o, 1);
    wait_done(d0, 50);
    chk("t1_rd_first", rd_rise_cyc, s);
    chk("t1_rd_last", rd_last_cyc, s + 3);
    chk("t1_rd_count", rd_cnt - r0, 4);
    chk("t1_valid_first", vld_rise_cyc, s + 2);
    chk("t1_last_hs", last_hs_cyc, s + 5);
    chk("t1_last_data", last_hs_data, 32'hA513EC2F);
    chk("t1_done_cyc", done_cyc, s + 6);
    chk("t1_words", hs_cnt - h0, 4);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_idle", busy_o, 0);

    // address wrap
    la = addr_log.size(); h0 = hs_cnt; d0 = done_cnt;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    start_dump(8'hFE, 9'd4, 1'b1, s);
    wait_done(d0, 50);
    chk("t2_words", hs_cnt - h0, 4);
    for (int i = 0; i < 4; i++) chk("t2_addr_seq", addr_log[la + i], exp_a[i]);
    chk("t2_last_data", last_hs_data, 32'hA501FE3D);

    // zero length
    r0 = rd_cnt; v0 = vld_cnt; d0 = done_cnt;
    start_dump(8'h55, 9'd0, 1'b1, s);
    wait_done(d0, 20);
    chk("t3_done_cyc", done_cyc, s);
    chk("t3_no_reads", rd_cnt - r0, 0);
    chk("t3_no_valid", vld_cnt - v0, 0);
    chk("t3_done_cnt", done_cnt - d0, 1);

    // full RAM under random backpressure
    h0 = hs_cnt; d0 = done_cnt; la = addr_log.size();
    rnd_mode = 1'b1;
    start_dump(8'h00, 9'h100, 1'b1, s);
    wait_done(d0, 5000);
    rnd_mode = 1'b0;
    chk("t4_words", hs_cnt - h0, 256);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_model_empty", exp_q.size(), 0);
    chk("t4_final_addr", addr_log[la + 255], 8'hFF);

    // start while busy is ignored
    h0 = hs_cnt; d0 = done_cnt;
    start_dump(8'h40, 9'd8, 1'b1, s);
    start_dump(8'h80, 9'd5, 1'b0, s);
    wait_done(d0, 50);
    v0 = vld_cnt;
    repeat (6) @(posedge clk);
    chk("t5_words", hs_cnt - h0, 8);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_quiet", vld_cnt - v0, 0);

    // reset mid-dump, then a clean dump
    h0 = hs_cnt; d0 = done_cnt; n = 0;
    start_dump(8'h20, 9'd16, 1'b1, s);
    while (hs_cnt - h0 < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t6_reach5", hs_cnt - h0 >= 5, 1);
    #3 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    h0 = hs_cnt; d0 = done_cnt;
    start_dump(8'h30, 9'd3, 1'b1, s);
    wait_done(d0, 50);
    chk("t6_words", hs_cnt - h0, 3);
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_model_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
